cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator CPU datapath (PC, program memory, decoder, RF, DM, ALU, flag register, accumulator).
- Breaks each instruction into FETCH/DECODE/MEM/EXEC/WB phases and generates every state-element enable.
- Adds a request/acknowledge handshake to a variable-latency data memory with a timeout, plus run/stop/single-step debug control.
- Sits between the instruction decoder's classification outputs and the clocked datapath blocks.

Parameters:
- TIMEOUT, 16, max cycles MEM waits for DM_ACK before a bus error (2..255).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-low
- RUN  in  1  run level; rising edge starts free-run, falling edge requests stop
- STEP  in  1  one-cycle pulse; executes exactly one instruction from HALT
- DEC_HALT  in  1  decoded instruction is HALT
- DEC_DM_RD  in  1  instruction reads DM
- DEC_DM_WR  in  1  instruction writes DM
- DEC_ACC_WR  in  1  instruction writes accumulator
- DEC_RF_WR  in  1  instruction writes RF
- DEC_FR_WR  in  1  instruction updates flags
- DEC_JMP  in  1  jump taken (condition resolved by decoder)
- DM_ACK  in  1  DM access complete, one-cycle pulse
- IR_EN  out  1  latch program-memory word into instruction register
- PC_EN  out  1  advance/load PC
- JMP_EN  out  1  PC loads jump address instead of incrementing (only with PC_EN)
- ACC_EN, RF_EN, FR_EN  out  1 each  write enables
- DM_REQ  out  1  DM access request
- DM_WE  out  1  DM write qualifier, valid with DM_REQ
- HALTED  out  1  FSM in HALT
- ERR  out  1  sticky bus-timeout error
- RETIRED  out  CNT_W  retired-instruction count

Behaviour:
- Reset (RST=0 at posedge): state HALT, HALTED=1, ERR=0, RETIRED=0, wait counter 0, stop/step flags 0, RUN edge register 0; all enables 0.
- RUN is edge-detected through one internal register; rise/fall evaluated each cycle.
- HALT: leave on RUN rise (free-run) or STEP=1 (step mode) -> FETCH. Both together: RUN wins. Ignored entirely while ERR=1.
- FETCH: IR_EN=1 -> DECODE.
- DECODE: no enables. DEC_HALT -> PC_EN=1, RETIRED+1, -> HALT. Else DEC_DM_RD|DEC_DM_WR -> MEM. Else -> EXEC. RD and WR together is illegal; treated as write.
- MEM: DM_REQ=1, DM_WE=DEC_DM_WR, held stable until ack. Wait counter clears on entry and increments each cycle.
  - DM_ACK=1: read -> EXEC, write -> WB.
  - Counter reaches TIMEOUT-1 with no ack: ERR=1, DM_REQ drops next cycle, -> HALT. PC and RETIRED unchanged.
- EXEC: one cycle for ALU settle -> WB.
- WB: ACC_EN=DEC_ACC_WR, RF_EN=DEC_RF_WR, FR_EN=DEC_FR_WR, PC_EN=1, JMP_EN=DEC_JMP, RETIRED+1 (wraps at 2^CNT_W). Then -> HALT if step mode or stop pending, else -> FETCH.
- Stop: a RUN fall in any non-HALT state sets the stop-pending flag. The current instruction completes, then HALT. The flag clears on entry to HALT.
- Latency with zero-wait DM (ack in first MEM cycle):
  - ALU/jump: 4 cycles.
  - DM read: 5 + extra wait cycles.
  - DM write: 4 + extra wait cycles.
- Outputs are decoded from the registered state and the decoder inputs, which are stable because the IR is latched. Outputs are zero in every state not listed above.
- Reset mid-MEM: DM_REQ low on the cycle after the reset edge; no partial commit.

Decomposition:
- Package cpu_ctrl_pkg: state_t enum (S_HALT, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_WB) and default TIMEOUT constant.
- Sub-module dm_wait_timer: clear/count/expire, width derived from TIMEOUT.

Test Plan:
- Reset, then one RUN rise, with ADD reg followed by HALT -> IR_EN at cycle 1, WB at cycle 4 with ACC_EN=FR_EN=PC_EN=1; HALT decoded at cycle 6; HALTED=1; RETIRED=2.
- DM read, DM_ACK after 3 wait cycles -> DM_REQ high exactly 4 cycles, DM_WE=0; ACC_EN in WB; 8 cycles total.
- DM write, DM_ACK never, TIMEOUT=16 -> DM_REQ high 16 cycles, ERR=1, HALT, RETIRED unchanged; subsequent RUN rise and STEP ignored.
- STEP pulse on a taken-jump instruction -> exactly one WB with PC_EN=JMP_EN=1, RETIRED+1, return to HALT; RUN held low throughout.
- RUN fall during MEM of a read -> instruction completes (ACC_EN pulses), then HALT; no further IR_EN.
- RST low during MEM -> next cycle HALTED=1, DM_REQ=0, RETIRED=0, ERR=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the accumulator CPU control sequencer.
//   state_t          : sequencer phase encoding
//   DEFAULT_TIMEOUT  : default number of cycles MEM waits for a DM acknowledge
//   DEFAULT_CNT_W    : default width of the retired-instruction counter
//   timer_width()    : bit width needed to count 0 .. timeout-1
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int DEFAULT_CNT_W   = 16;

  // A timeout of 2 still needs one bit to distinguish the two wait cycles.
  function automatic int timer_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/dm_wait_timer.sv
// ---------------------------------------------------------------------------
// dm_wait_timer
// Counts the cycles spent waiting on the data memory and flags the last
// permitted wait cycle.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous reset, active-low
//   clear    in   force the count back to zero
//   count_en in   advance the count by one this cycle
//   expired  out  count has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module dm_wait_timer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = timer_width(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Saturates at LAST so a stalled sequencer can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control FSM for the 8-bit accumulator CPU. Splits every
// instruction into FETCH/DECODE/MEM/EXEC/WB, drives all datapath enables,
// handshakes with a variable-latency data memory (with timeout) and provides
// run/stop/single-step debug control.
// Ports:
//   CLK, RST             clock, synchronous active-low reset
//   RUN, STEP            run level (edge detected), single-step pulse
//   DEC_*                instruction classification from the decoder
//   DM_ACK               data memory access complete pulse
//   IR_EN, PC_EN, JMP_EN instruction register / program counter controls
//   ACC_EN, RF_EN, FR_EN accumulator, register file, flag write enables
//   DM_REQ, DM_WE        data memory request and write qualifier
//   HALTED, ERR          in HALT state, sticky bus-timeout error
//   RETIRED              count of completed instructions
// ---------------------------------------------------------------------------
module cpu_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             DEC_HALT,
  input  logic             DEC_DM_RD,
  input  logic             DEC_DM_WR,
  input  logic             DEC_ACC_WR,
  input  logic             DEC_RF_WR,
  input  logic             DEC_FR_WR,
  input  logic             DEC_JMP,
  input  logic             DM_ACK,
  output logic             IR_EN,
  output logic             PC_EN,
  output logic             JMP_EN,
  output logic             ACC_EN,
  output logic             RF_EN,
  output logic             FR_EN,
  output logic             DM_REQ,
  output logic             DM_WE,
  output logic             HALTED,
  output logic             ERR,
  output logic [CNT_W-1:0] RETIRED
);

  state_t state;
  state_t next_state;

  logic run_q;
  logic run_rise;
  logic run_fall;
  logic step_mode;
  logic stop_pending;
  logic err;
  logic [CNT_W-1:0] retired;

  logic timer_expired;
  logic timeout_hit;
  logic retire;
  logic enter_halt;
  logic leave_halt;

  assign run_rise = RUN & ~run_q;
  assign run_fall = ~RUN & run_q;

  // Acknowledge wins over an expiry arriving in the same cycle.
  assign timeout_hit = (state == S_MEM) && !DM_ACK && timer_expired;

  // An instruction retires in WB, or in DECODE when it is itself a HALT.
  assign retire = (state == S_WB) || ((state == S_DECODE) && DEC_HALT);

  assign enter_halt = (next_state == S_HALT) && (state != S_HALT);
  assign leave_halt = (state == S_HALT) && (next_state == S_FETCH);

  // The timer is held at zero outside MEM, so it always starts from zero on
  // the first MEM cycle.
  dm_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (state != S_MEM),
    .count_en (state == S_MEM),
    .expired  (timer_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_HALT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A RUN fall seen during WB itself also ends free-run
  // immediately rather than starting another fetch.
  always_comb begin
    next_state = state;
    case (state)
      S_HALT: begin
        if (!err && (run_rise || STEP)) begin
          next_state = S_FETCH;
        end
      end
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (DEC_HALT) begin
          next_state = S_HALT;
        end else if (DEC_DM_RD || DEC_DM_WR) begin
          next_state = S_MEM;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_MEM: begin
        if (DM_ACK) begin
          next_state = DEC_DM_WR ? S_WB : S_EXEC;
        end else if (timer_expired) begin
          next_state = S_HALT;
        end
      end
      S_EXEC: next_state = S_WB;
      S_WB: begin
        if (step_mode || stop_pending || run_fall) begin
          next_state = S_HALT;
        end else begin
          next_state = S_FETCH;
        end
      end
      default: next_state = S_HALT;
    endcase
  end

  // Output decode. Decoder inputs are stable from DECODE onward because the
  // instruction register only loads in FETCH.
  always_comb begin
    IR_EN  = 1'b0;
    PC_EN  = 1'b0;
    JMP_EN = 1'b0;
    ACC_EN = 1'b0;
    RF_EN  = 1'b0;
    FR_EN  = 1'b0;
    DM_REQ = 1'b0;
    DM_WE  = 1'b0;
    case (state)
      S_FETCH: IR_EN = 1'b1;
      S_DECODE: PC_EN = DEC_HALT;
      S_MEM: begin
        DM_REQ = 1'b1;
        DM_WE  = DEC_DM_WR;
      end
      S_WB: begin
        ACC_EN = DEC_ACC_WR;
        RF_EN  = DEC_RF_WR;
        FR_EN  = DEC_FR_WR;
        PC_EN  = 1'b1;
        JMP_EN = DEC_JMP;
      end
      default: ;
    endcase
  end

  // Debug control flags. Step mode is chosen at the moment HALT is left;
  // when RUN rises together with STEP, free-run takes priority.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      run_q        <= 1'b0;
      step_mode    <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      run_q <= RUN;
      if (leave_halt) begin
        step_mode <= ~run_rise;
      end else if (enter_halt) begin
        step_mode <= 1'b0;
      end
      if (enter_halt) begin
        stop_pending <= 1'b0;
      end else if (run_fall && (state != S_HALT)) begin
        stop_pending <= 1'b1;
      end
    end
  end

  // Sticky bus error and retired-instruction counter (wraps naturally).
  always_ff @(posedge CLK) begin
    if (!RST) begin
      err     <= 1'b0;
      retired <= '0;
    end else begin
      if (timeout_hit) begin
        err <= 1'b1;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign HALTED  = (state == S_HALT);
  assign ERR     = err;
  assign RETIRED = retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed testbench for cpu_sequencer. Each task drives one scenario and
// compares outputs against hand-derived per-cycle values. Cycle 0 of a
// scenario is the cycle in which RUN rises or STEP pulses.
// Enable vector en = {IR,PC,JMP,ACC,RF,FR,DM_REQ,DM_WE}.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic        CLK;
  logic        RST;
  logic        RUN;
  logic        STEP;
  logic        DEC_HALT;
  logic        DEC_DM_RD;
  logic        DEC_DM_WR;
  logic        DEC_ACC_WR;
  logic        DEC_RF_WR;
  logic        DEC_FR_WR;
  logic        DEC_JMP;
  logic        DM_ACK;
  logic        IR_EN;
  logic        PC_EN;
  logic        JMP_EN;
  logic        ACC_EN;
  logic        RF_EN;
  logic        FR_EN;
  logic        DM_REQ;
  logic        DM_WE;
  logic        HALTED;
  logic        ERR;
  logic [15:0] RETIRED;

  logic [7:0] en;
  int checks;
  int fails;

  assign en = {IR_EN, PC_EN, JMP_EN, ACC_EN, RF_EN, FR_EN, DM_REQ, DM_WE};

  cpu_sequencer #(
    .TIMEOUT (16),
    .CNT_W   (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RUN        (RUN),
    .STEP       (STEP),
    .DEC_HALT   (DEC_HALT),
    .DEC_DM_RD  (DEC_DM_RD),
    .DEC_DM_WR  (DEC_DM_WR),
    .DEC_ACC_WR (DEC_ACC_WR),
    .DEC_RF_WR  (DEC_RF_WR),
    .DEC_FR_WR  (DEC_FR_WR),
    .DEC_JMP    (DEC_JMP),
    .DM_ACK     (DM_ACK),
    .IR_EN      (IR_EN),
    .PC_EN      (PC_EN),
    .JMP_EN     (JMP_EN),
    .ACC_EN     (ACC_EN),
    .RF_EN      (RF_EN),
    .FR_EN      (FR_EN),
    .DM_REQ     (DM_REQ),
    .DM_WE      (DM_WE),
    .HALTED     (HALTED),
    .ERR        (ERR),
    .RETIRED    (RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  // Load the decoder classification of the "current instruction".
  task automatic set_dec(input logic halt, input logic rd, input logic wr,
                         input logic acc, input logic rf, input logic fr,
                         input logic jmp);
    DEC_HALT   = halt;
    DEC_DM_RD  = rd;
    DEC_DM_WR  = wr;
    DEC_ACC_WR = acc;
    DEC_RF_WR  = rf;
    DEC_FR_WR  = fr;
    DEC_JMP    = jmp;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (HALTED !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_halted: got %b expected 1", HALTED);
    end
    checks++;
    if (ERR !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_err: got %b expected 0", ERR);
    end
    checks++;
    if (RETIRED !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_retired: got %0d expected 0", RETIRED);
    end
    checks++;
    if (en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_enables: got %b expected 00000000", en);
    end
    RST = 1'b1;
    next_cycle();
    checks++;
    if (HALTED !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_idle: got %b expected 1", HALTED);
    end
  endtask

  // ADD reg (ACC+FR write) followed by a HALT instruction in free-run.
  task automatic test_alu_then_halt();
    set_dec(0, 0, 0, 1, 0, 1, 0);
    RUN = 1'b1;
    next_cycle();
    checks++;
    if (en !== 8'h80) begin
      fails++;
      $display("[TB] FAIL alu_fetch: got %b expected 10000000", en);
    end
    next_cycle();
    checks++;
    if (en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL alu_decode: got %b expected 00000000", en);
    end
    next_cycle();
    checks++;
    if (en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL alu_exec: got %b expected 00000000", en);
    end
    next_cycle();
    checks++;
    if (en !== 8'h54) begin
      fails++;
      $display("[TB] FAIL alu_wb: got %b expected 01010100", en);
    end
    set_dec(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    checks++;
    if (en !== 8'h80 || RETIRED !== 16'd1) begin
      fails++;
      $display("[TB] FAIL halt_fetch: got en=%b retired=%0d expected 10000000 1", en, RETIRED);
    end
    next_cycle();
    checks++;
    if (en !== 8'h40 || HALTED !== 1'b0) begin
      fails++;
      $display("[TB] FAIL halt_decode: got en=%b halted=%b expected 01000000 0", en, HALTED);
    end
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || RETIRED !== 16'd2 || en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL halt_done: got halted=%b retired=%0d en=%b expected 1 2 00000000", HALTED, RETIRED, en);
    end
    RUN = 1'b0;
    next_cycle();
  endtask

  // DM read acknowledged in the fourth MEM cycle: 8 cycles total.
  task automatic test_dm_read();
    int req_cycles;
    req_cycles = 0;
    set_dec(0, 1, 0, 1, 0, 0, 0);
    RUN = 1'b1;
    next_cycle();
    next_cycle();
    for (int i = 3; i <= 6; i++) begin
      next_cycle();
      if (DM_REQ === 1'b1 && DM_WE === 1'b0) req_cycles++;
      if (i == 6) DM_ACK = 1'b1;
    end
    next_cycle();
    DM_ACK = 1'b0;
    if (DM_REQ === 1'b1) req_cycles++;
    checks++;
    if (en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL read_exec: got %b expected 00000000", en);
    end
    checks++;
    if (req_cycles != 4) begin
      fails++;
      $display("[TB] FAIL read_req_cycles: got %0d expected 4", req_cycles);
    end
    next_cycle();
    checks++;
    if (en !== 8'h50) begin
      fails++;
      $display("[TB] FAIL read_wb: got %b expected 01010000", en);
    end
    set_dec(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || RETIRED !== 16'd4) begin
      fails++;
      $display("[TB] FAIL read_halt: got halted=%b retired=%0d expected 1 4", HALTED, RETIRED);
    end
    RUN = 1'b0;
    next_cycle();
  endtask

  // Single step on a taken jump with RUN held low.
  task automatic test_step_jump();
    int ir_count;
    ir_count = 0;
    set_dec(0, 0, 0, 0, 0, 0, 1);
    STEP = 1'b1;
    next_cycle();
    STEP = 1'b0;
    checks++;
    if (en !== 8'h80) begin
      fails++;
      $display("[TB] FAIL step_fetch: got %b expected 10000000", en);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (en !== 8'h60) begin
      fails++;
      $display("[TB] FAIL step_wb: got %b expected 01100000", en);
    end
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || RETIRED !== 16'd5) begin
      fails++;
      $display("[TB] FAIL step_halt: got halted=%b retired=%0d expected 1 5", HALTED, RETIRED);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (IR_EN === 1'b1) ir_count++;
    end
    checks++;
    if (ir_count != 0) begin
      fails++;
      $display("[TB] FAIL step_no_refetch: got %0d fetches expected 0", ir_count);
    end
  endtask

  // RUN falls while a read is waiting in MEM; the read still completes.
  task automatic test_stop_during_mem();
    int ir_count;
    ir_count = 0;
    set_dec(0, 1, 0, 1, 0, 0, 0);
    RUN = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    RUN = 1'b0;
    next_cycle();
    DM_ACK = 1'b1;
    next_cycle();
    DM_ACK = 1'b0;
    next_cycle();
    checks++;
    if (en !== 8'h50) begin
      fails++;
      $display("[TB] FAIL stop_wb: got %b expected 01010000", en);
    end
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || RETIRED !== 16'd6) begin
      fails++;
      $display("[TB] FAIL stop_halt: got halted=%b retired=%0d expected 1 6", HALTED, RETIRED);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (IR_EN === 1'b1) ir_count++;
    end
    checks++;
    if (ir_count != 0) begin
      fails++;
      $display("[TB] FAIL stop_no_refetch: got %0d fetches expected 0", ir_count);
    end
  endtask

  // DM write never acknowledged: 16 request cycles then sticky error.
  task automatic test_timeout();
    int req_cycles;
    int ir_count;
    req_cycles = 0;
    ir_count = 0;
    set_dec(0, 0, 1, 0, 0, 0, 0);
    RUN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (DM_REQ === 1'b1) req_cycles++;
      if (i == 18) begin
        checks++;
        if (en !== 8'h03 || ERR !== 1'b0) begin
          fails++;
          $display("[TB] FAIL timeout_last_mem: got en=%b err=%b expected 00000011 0", en, ERR);
        end
      end
      if (i == 19) begin
        checks++;
        if (ERR !== 1'b1 || HALTED !== 1'b1 || en !== 8'h00) begin
          fails++;
          $display("[TB] FAIL timeout_err: got err=%b halted=%b en=%b expected 1 1 00000000", ERR, HALTED, en);
        end
      end
    end
    checks++;
    if (req_cycles != 16) begin
      fails++;
      $display("[TB] FAIL timeout_req_cycles: got %0d expected 16", req_cycles);
    end
    checks++;
    if (RETIRED !== 16'd6) begin
      fails++;
      $display("[TB] FAIL timeout_retired: got %0d expected 6", RETIRED);
    end
    RUN = 1'b0;
    next_cycle();
    RUN = 1'b1;
    STEP = 1'b1;
    next_cycle();
    STEP = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (IR_EN === 1'b1) ir_count++;
    end
    checks++;
    if (ir_count != 0 || HALTED !== 1'b1 || ERR !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_locked: got fetches=%0d halted=%b err=%b expected 0 1 1", ir_count, HALTED, ERR);
    end
  endtask

  // Reset asserted while a read is outstanding in MEM.
  task automatic test_reset_mid_mem();
    RUN = 1'b0;
    STEP = 1'b0;
    RST = 1'b0;
    next_cycle();
    RST = 1'b1;
    checks++;
    if (ERR !== 1'b0 || RETIRED !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_clears_err: got err=%b retired=%0d expected 0 0", ERR, RETIRED);
    end
    next_cycle();
    set_dec(0, 1, 0, 1, 0, 0, 0);
    RUN = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (en !== 8'h02) begin
      fails++;
      $display("[TB] FAIL rstmem_req: got %b expected 00000010", en);
    end
    RST = 1'b0;
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || DM_REQ !== 1'b0 || RETIRED !== 16'd0 || ERR !== 1'b0 || en !== 8'h00) begin
      fails++;
      $display("[TB] FAIL rstmem_after: got halted=%b req=%b retired=%0d err=%b en=%b expected 1 0 0 0 00000000", HALTED, DM_REQ, RETIRED, ERR, en);
    end
    RST = 1'b1;
    RUN = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (HALTED !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rstmem_idle: got %b expected 1", HALTED);
    end
  endtask

  // RUN rise and STEP together: free-run wins, so a second fetch follows WB.
  task automatic test_run_wins();
    set_dec(0, 0, 0, 0, 1, 0, 0);
    RUN = 1'b1;
    STEP = 1'b1;
    next_cycle();
    STEP = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (en !== 8'h48) begin
      fails++;
      $display("[TB] FAIL runwins_wb: got %b expected 01001000", en);
    end
    next_cycle();
    checks++;
    if (en !== 8'h80) begin
      fails++;
      $display("[TB] FAIL runwins_refetch: got %b expected 10000000", en);
    end
    RUN = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (en !== 8'h48) begin
      fails++;
      $display("[TB] FAIL runwins_second_wb: got %b expected 01001000", en);
    end
    next_cycle();
    checks++;
    if (HALTED !== 1'b1 || RETIRED !== 16'd2) begin
      fails++;
      $display("[TB] FAIL runwins_halt: got halted=%b retired=%0d expected 1 2", HALTED, RETIRED);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    RST    = 1'b0;
    RUN    = 1'b0;
    STEP   = 1'b0;
    DM_ACK = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] starting cpu_sequencer directed tests");
    test_reset();
    test_alu_then_halt();
    test_dm_read();
    test_step_jump();
    test_stop_during_mem();
    test_timeout();
    test_reset_mid_mem();
    test_run_wins();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
